fp_exec_sequencer: RTL and testbench

//  Execute-side consumer of the decode stage's registered FP op bundle (one-hot fadd/fsub/fmul/fdiv/fsqrt, FRD1/FRD2, RD).

---
 rtl/fp_exec_sequencer.sv | 216 +++++++++++++++++++++
 tb/tb_fp_exec_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_exec_sequencer.sv
// fp_exec_sequencer
//   Execute-side sequencer for multi-cycle FP arithmetic (add/sub/mul/div/sqrt).
//   Captures one op from the ID/EX register, issues it to the FPU core with a
//   start/done handshake, stalls decode while the op is outstanding, then
//   presents a single FP register-file write toward memory/writeback.
//   Optional feature macro: FPU_TIMEOUT_EN enables a WAIT-state watchdog that
//   retires a quiet NaN with the NV flag when the FPU core never answers.
module fp_exec_sequencer #(
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fadd_e,
  input  logic              fsub_e,
  input  logic              fmul_e,
  input  logic              fdiv_e,
  input  logic              fsqrt_e,
  input  logic              fregwrite_e,
  input  logic [DATA_W-1:0] frd1_e,
  input  logic [DATA_W-1:0] frd2_e,
  input  logic [4:0]        rd_e,
  input  logic              hold_i,
  input  logic              fflags_clr,
  output logic              fpu_start,
  output logic [2:0]        fpu_op,
  output logic [DATA_W-1:0] fpu_a,
  output logic [DATA_W-1:0] fpu_b,
  input  logic              fpu_done,
  input  logic [DATA_W-1:0] fpu_result,
  input  logic [4:0]        fpu_flags,
  output logic              stall_o,
  output logic [DATA_W-1:0] result_m,
  output logic [4:0]        rd_m,
  output logic              fregwrite_m,
  output logic [4:0]        fflags_acc,
  output logic              timeout_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_WB    = 2'd3;

  // The watchdog counter must be able to reach TIMEOUT_CYCLES-1.
  if (TIMEOUT_CYCLES > (2 ** CNT_W)) begin : g_cnt_w_too_small
  end

  logic [1:0] state_r;
  logic [1:0] state_nxt_s;
  logic       req_s;
  logic       accept_s;
  logic       done_s;
  logic       retire_s;
  logic [2:0] op_s;
  logic       fw_r;
  logic [4:0] flags_r;

  assign req_s    = fadd_e | fsub_e | fmul_e | fdiv_e | fsqrt_e;
  assign accept_s = (state_r == S_IDLE) && req_s;
  // fpu_done is only meaningful while an op is outstanding
  assign done_s   = (state_r == S_WAIT) && fpu_done;
  assign retire_s = (state_r == S_WB) && !hold_i;

  // Decode stalls from the cycle the op is seen until the result has arrived.
  assign stall_o     = accept_s || (state_r == S_ISSUE) || (state_r == S_WAIT);
  assign fregwrite_m = retire_s && fw_r;

`ifdef FPU_TIMEOUT_EN
  localparam logic [DATA_W-1:0] QNAN = DATA_W'(32'h7FC0_0000);
  logic [CNT_W-1:0] cnt_r;
  logic             expire_s;

  // fpu_done in the same cycle as expiry takes precedence
  assign expire_s = (state_r == S_WAIT) && !fpu_done &&
                    (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));

  // Watchdog: counts WAIT cycles, restarts for every issued op
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (state_r == S_WAIT) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= {CNT_W{1'b0}};
    end
  end

  // One-cycle abort pulse, visible in the first WB cycle after expiry
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timeout_o <= 1'b0;
    end else begin
      timeout_o <= expire_s;
    end
  end
`else
  assign timeout_o = 1'b0;
`endif

  // Op code selection; malformed multi-hot bundles resolve div>sqrt>mul>sub>add
  always_comb begin
    op_s = 3'd0;
    if (fdiv_e) begin
      op_s = 3'd3;
    end else if (fsqrt_e) begin
      op_s = 3'd4;
    end else if (fmul_e) begin
      op_s = 3'd2;
    end else if (fsub_e) begin
      op_s = 3'd1;
    end else begin
      op_s = 3'd0;
    end
  end

  // Next-state logic for the IDLE->ISSUE->WAIT->WB sequence
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (req_s) begin
          state_nxt_s = S_ISSUE;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_ISSUE: begin
        state_nxt_s = S_WAIT;
      end
      S_WAIT: begin
`ifdef FPU_TIMEOUT_EN
        if (fpu_done || expire_s) begin
`else
        if (fpu_done) begin
`endif
          state_nxt_s = S_WB;
        end else begin
          state_nxt_s = S_WAIT;
        end
      end
      S_WB: begin
        if (!hold_i) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_WB;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Start pulse fires in the single ISSUE cycle that follows acceptance
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fpu_start <= 1'b0;
    end else begin
      fpu_start <= accept_s;
    end
  end

  // Operand/destination capture at acceptance, result capture at completion
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fpu_a    <= {DATA_W{1'b0}};
      fpu_b    <= {DATA_W{1'b0}};
      fpu_op   <= 3'd0;
      rd_m     <= 5'd0;
      fw_r     <= 1'b0;
      result_m <= {DATA_W{1'b0}};
      flags_r  <= 5'd0;
    end else begin
      if (accept_s) begin
        fpu_a  <= frd1_e;
        fpu_b  <= frd2_e;
        fpu_op <= op_s;
        rd_m   <= rd_e;
        fw_r   <= fregwrite_e;
      end
      if (done_s) begin
        result_m <= fpu_result;
        flags_r  <= fpu_flags;
      end
`ifdef FPU_TIMEOUT_EN
      else if (expire_s) begin
        result_m <= QNAN;
        flags_r  <= 5'b10000;
      end
`endif
    end
  end

  // Sticky exception flags; an explicit clear discards a same-cycle retirement
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fflags_acc <= 5'd0;
    end else if (fflags_clr) begin
      fflags_acc <= 5'd0;
    end else if (retire_s) begin
      fflags_acc <= fflags_acc | flags_r;
    end
  end

endmodule

// File: tb/tb_fp_exec_sequencer.sv
// Testbench for fp_exec_sequencer: directed scenarios plus randomized ops,
// checked against a transaction-level expectation model kept in the bench.
module tb_fp_exec_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  opf;           // {fsqrt, fdiv, fmul, fsub, fadd}
  logic        fregwrite_e;
  logic [31:0] frd1_e, frd2_e;
  logic [4:0]  rd_e;
  logic        hold_i, fflags_clr;
  logic        fpu_start;
  logic [2:0]  fpu_op;
  logic [31:0] fpu_a, fpu_b;
  logic        fpu_done;
  logic [31:0] fpu_result;
  logic [4:0]  fpu_flags;
  logic        stall_o;
  logic [31:0] result_m;
  logic [4:0]  rd_m;
  logic        fregwrite_m;
  logic [4:0]  fflags_acc;
  logic        timeout_o;

  int          checks = 0;
  int          passed = 0;
  logic [4:0]  acc_exp;
  logic [31:0] last_res;

  always #5 clk = ~clk;

  fp_exec_sequencer dut (
    .clk(clk), .rst(rst),
    .fadd_e(opf[0]), .fsub_e(opf[1]), .fmul_e(opf[2]), .fdiv_e(opf[3]), .fsqrt_e(opf[4]),
    .fregwrite_e(fregwrite_e), .frd1_e(frd1_e), .frd2_e(frd2_e), .rd_e(rd_e),
    .hold_i(hold_i), .fflags_clr(fflags_clr),
    .fpu_start(fpu_start), .fpu_op(fpu_op), .fpu_a(fpu_a), .fpu_b(fpu_b),
    .fpu_done(fpu_done), .fpu_result(fpu_result), .fpu_flags(fpu_flags),
    .stall_o(stall_o), .result_m(result_m), .rd_m(rd_m), .fregwrite_m(fregwrite_m),
    .fflags_acc(fflags_acc), .timeout_o(timeout_o)
  );

  // Op code the FPU should see: div beats sqrt beats mul beats sub beats add.
  function automatic logic [2:0] ref_op(input logic [4:0] f);
    if (f[3]) return 3'd3;
    if (f[4]) return 3'd4;
    if (f[2]) return 3'd2;
    if (f[1]) return 3'd1;
    return 3'd0;
  endfunction

  // One full op: accept, issue, lat WAIT cycles (done on the last), hold_n
  // held WB cycles, then the retiring cycle, then one idle cycle.
  task automatic run_op(input logic [4:0] f, input logic fw, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input int lat,
                        input int hold_n, input logic [31:0] res, input logic [4:0] rfl,
                        input logic clr_at_wb);
    logic [2:0] exp_op;
    int stalls;
    exp_op = ref_op(f);
    // cycle N: op visible in E
    @(negedge clk);
    opf = f; fregwrite_e = fw; frd1_e = a; frd2_e = b; rd_e = rd;
    hold_i = 1'b0; fflags_clr = 1'b0; fpu_done = 1'b0;
    #1;
    stalls = stall_o ? 1 : 0;
    checks++; if (stall_o !== 1'b1) $display("FAIL accept_stall: got %b expected 1", stall_o); else passed++;
    checks++; if (fpu_start !== 1'b0) $display("FAIL early_start: got %b expected 0", fpu_start); else passed++;
    // cycle N+1: start pulse with latched operands
    @(negedge clk); #1;
    if (stall_o) stalls++;
    checks++; if (fpu_start !== 1'b1) $display("FAIL start_pulse: got %b expected 1", fpu_start); else passed++;
    checks++; if (fpu_op !== exp_op) $display("FAIL fpu_op: got %0d expected %0d", fpu_op, exp_op); else passed++;
    checks++; if ({fpu_a, fpu_b} !== {a, b}) $display("FAIL operands: got %h %h expected %h %h", fpu_a, fpu_b, a, b); else passed++;
    // WAIT cycles, decode keeps presenting the same op while stalled
    for (int i = 1; i <= lat; i++) begin
      @(negedge clk);
      fpu_done   = (i == lat);
      fpu_result = (i == lat) ? res : $urandom;
      fpu_flags  = (i == lat) ? rfl : 5'($urandom);
      #1;
      if (stall_o) stalls++;
      checks++; if (fpu_start !== 1'b0) $display("FAIL start_once: got %b expected 0 wait=%0d", fpu_start, i); else passed++;
      checks++; if ({fpu_a, fpu_b} !== {a, b}) $display("FAIL operand_stable: got %h %h expected %h %h", fpu_a, fpu_b, a, b); else passed++;
    end
    checks++; if (stalls != lat + 2) $display("FAIL stall_length: got %0d expected %0d", stalls, lat + 2); else passed++;
    // WB: hold_n held cycles then the retiring cycle
    for (int h = 0; h <= hold_n; h++) begin
      @(negedge clk);
      fpu_done = 1'b0; fpu_result = $urandom; fpu_flags = 5'($urandom);
      hold_i = (h < hold_n);
      fflags_clr = (h == hold_n) && clr_at_wb;
      #1;
      checks++; if (stall_o !== 1'b0) $display("FAIL wb_stall: got %b expected 0", stall_o); else passed++;
      checks++; if ({result_m, rd_m} !== {res, rd}) $display("FAIL wb_result: got %h/%0d expected %h/%0d", result_m, rd_m, res, rd); else passed++;
      checks++; if (fregwrite_m !== ((h == hold_n) ? fw : 1'b0)) $display("FAIL wb_strobe: got %b expected %b hold_cycle=%0d", fregwrite_m, (h == hold_n) ? fw : 1'b0, h); else passed++;
      if (h == 0) begin
        checks++; if (timeout_o !== 1'b0) $display("FAIL no_timeout: got %b expected 0", timeout_o); else passed++;
      end
    end
    if (clr_at_wb) acc_exp = 5'd0; else acc_exp = acc_exp | rfl;
    last_res = res;
    // following cycle: decode has moved on, nothing pending
    @(negedge clk);
    opf = 5'd0; hold_i = 1'b0; fflags_clr = 1'b0;
    #1;
    checks++; if ({stall_o, fpu_start, fregwrite_m} !== 3'b000) $display("FAIL after_wb: got %b expected 000", {stall_o, fpu_start, fregwrite_m}); else passed++;
    checks++; if (fflags_acc !== acc_exp) $display("FAIL fflags_acc: got %b expected %b", fflags_acc, acc_exp); else passed++;
  endtask

  task automatic test_reset;
    rst = 1'b0; opf = 5'd0; fregwrite_e = 1'b0; frd1_e = 32'd0; frd2_e = 32'd0; rd_e = 5'd0;
    hold_i = 1'b0; fflags_clr = 1'b0; fpu_done = 1'b0; fpu_result = 32'd0; fpu_flags = 5'd0;
    acc_exp = 5'd0; last_res = 32'd0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if ({fpu_start, stall_o, fregwrite_m, timeout_o, fpu_op, rd_m, fflags_acc} !== 17'd0)
      $display("FAIL reset_ctrl: got %h expected 0", {fpu_start, stall_o, fregwrite_m, timeout_o, fpu_op, rd_m, fflags_acc}); else passed++;
    checks++; if ({result_m, fpu_a, fpu_b} !== 96'd0) $display("FAIL reset_data: got %h expected 0", {result_m, fpu_a, fpu_b}); else passed++;
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_min_latency;
    run_op(5'b00001, 1'b1, 32'h3F80_0000, 32'h4000_0000, 5'd7, 1, 0, 32'h4040_0000, 5'b00000, 1'b0);
  endtask

  task automatic test_long_div;
    run_op(5'b01000, 1'b1, 32'h4120_0000, 32'h4040_0000, 5'd12, 20, 0, 32'h4055_5555, 5'b00001, 1'b0);
  endtask

  task automatic test_wb_hold;
    run_op(5'b00100, 1'b1, 32'h4000_0000, 32'h4080_0000, 5'd3, 2, 3, 32'h4100_0000, 5'b00000, 1'b0);
  endtask

  task automatic test_flags;
    @(negedge clk); fflags_clr = 1'b1; #1;
    @(negedge clk); fflags_clr = 1'b0; #1;
    acc_exp = 5'd0;
    checks++; if (fflags_acc !== 5'd0) $display("FAIL flags_clear0: got %b expected 00000", fflags_acc); else passed++;
    run_op(5'b00010, 1'b1, 32'h1, 32'h2, 5'd1, 1, 0, 32'h3, 5'b00001, 1'b0);
    run_op(5'b10000, 1'b0, 32'h4, 32'h5, 5'd2, 3, 1, 32'h6, 5'b10000, 1'b0);
    @(negedge clk); fflags_clr = 1'b1; #1;
    @(negedge clk); fflags_clr = 1'b0; #1;
    acc_exp = 5'd0;
    checks++; if (fflags_acc !== 5'd0) $display("FAIL flags_clear: got %b expected 00000", fflags_acc); else passed++;
    // a clear in the retiring cycle drops that op's flags
    run_op(5'b00001, 1'b1, 32'h7, 32'h8, 5'd9, 1, 0, 32'h9, 5'b00100, 1'b1);
  endtask

  task automatic test_priority;
    run_op(5'b11111, 1'b1, 32'hA, 32'hB, 5'd4, 1, 0, 32'hC, 5'd0, 1'b0);
    run_op(5'b10110, 1'b1, 32'hD, 32'hE, 5'd5, 1, 0, 32'hF, 5'd0, 1'b0);
    run_op(5'b00110, 1'b1, 32'h10, 32'h11, 5'd6, 1, 0, 32'h12, 5'd0, 1'b0);
    run_op(5'b00011, 1'b1, 32'h13, 32'h14, 5'd8, 1, 0, 32'h15, 5'd0, 1'b0);
  endtask

  task automatic test_no_effect;
    // no arithmetic flag, stray fpu_done: nothing must move
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      opf = 5'd0; fregwrite_e = 1'b1; frd1_e = $urandom; frd2_e = $urandom; rd_e = 5'($urandom);
      fpu_done = (i == 1); fpu_result = $urandom; fpu_flags = 5'b11111;
      #1;
      checks++; if ({stall_o, fpu_start, fregwrite_m} !== 3'b000) $display("FAIL idle_quiet: got %b expected 000", {stall_o, fpu_start, fregwrite_m}); else passed++;
    end
    @(negedge clk); fpu_done = 1'b0; #1;
    checks++; if (result_m !== last_res) $display("FAIL stray_done: got %h expected %h", result_m, last_res); else passed++;
    checks++; if (fflags_acc !== acc_exp) $display("FAIL stray_flags: got %b expected %b", fflags_acc, acc_exp); else passed++;
  endtask

  task automatic test_random;
    for (int n = 0; n < 24; n++) begin
      run_op(5'($urandom_range(1, 31)), 1'($urandom), $urandom, $urandom, 5'($urandom),
             int'($urandom_range(1, 6)), int'($urandom_range(0, 3)), $urandom,
             5'($urandom), ($urandom_range(0, 7) == 0));
    end
  endtask

  task automatic test_back_to_back;
    run_op(5'b00001, 1'b1, 32'h11, 32'h22, 5'd30, 1, 0, 32'h33, 5'b00010, 1'b0);
    run_op(5'b00010, 1'b1, 32'h44, 32'h55, 5'd31, 1, 0, 32'h66, 5'b01000, 1'b0);
  endtask

  task automatic test_reset_mid_op;
    @(negedge clk);
    opf = 5'b01000; fregwrite_e = 1'b1; frd1_e = 32'hDEAD_BEEF; frd2_e = 32'h1234_5678; rd_e = 5'd17;
    fpu_done = 1'b0; hold_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);                        // in WAIT, core still busy
    rst = 1'b0; opf = 5'd0;
    #1;
    checks++; if ({fpu_start, stall_o, fregwrite_m, fpu_op, rd_m, fflags_acc} !== 16'd0)
      $display("FAIL rst_mid_ctrl: got %h expected 0", {fpu_start, stall_o, fregwrite_m, fpu_op, rd_m, fflags_acc}); else passed++;
    checks++; if ({result_m, fpu_a, fpu_b} !== 96'd0) $display("FAIL rst_mid_data: got %h expected 0", {result_m, fpu_a, fpu_b}); else passed++;
    @(negedge clk); rst = 1'b1;
    acc_exp = 5'd0; last_res = 32'd0;
    @(negedge clk);
    fpu_done = 1'b1; fpu_result = 32'hCAFE_F00D; fpu_flags = 5'b11111;
    #1;
    checks++; if (fregwrite_m !== 1'b0) $display("FAIL late_done_strobe: got %b expected 0", fregwrite_m); else passed++;
    @(negedge clk); fpu_done = 1'b0; #1;
    checks++; if ({stall_o, fpu_start, fregwrite_m} !== 3'b000) $display("FAIL late_done_ctrl: got %b expected 000", {stall_o, fpu_start, fregwrite_m}); else passed++;
    checks++; if ({result_m, fflags_acc} !== 37'd0) $display("FAIL late_done_data: got %h expected 0", {result_m, fflags_acc}); else passed++;
  endtask

`ifdef FPU_TIMEOUT_EN
  task automatic test_timeout;
    int n;
    @(negedge clk);
    opf = 5'b00100; fregwrite_e = 1'b1; frd1_e = 32'h1; frd2_e = 32'h2; rd_e = 5'd21;
    fpu_done = 1'b0; hold_i = 1'b0; fflags_clr = 1'b0;
    #1;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      n++;
      if (!stall_o) break;
    end
    checks++; if (n != 64 + 2) $display("FAIL timeout_len: got %0d expected %0d", n, 64 + 2); else passed++;
    checks++; if (timeout_o !== 1'b1) $display("FAIL timeout_pulse: got %b expected 1", timeout_o); else passed++;
    checks++; if (result_m !== 32'h7FC0_0000) $display("FAIL timeout_result: got %h expected 7fc00000", result_m); else passed++;
    acc_exp = acc_exp | 5'b10000;
    last_res = 32'h7FC0_0000;
    @(negedge clk); opf = 5'd0; #1;
    checks++; if (timeout_o !== 1'b0) $display("FAIL timeout_once: got %b expected 0", timeout_o); else passed++;
    checks++; if (fflags_acc !== acc_exp) $display("FAIL timeout_flags: got %b expected %b", fflags_acc, acc_exp); else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_min_latency();
    test_long_div();
    test_wb_hold();
    test_flags();
    test_priority();
    test_no_effect();
    test_back_to_back();
    test_random();
`ifdef FPU_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_op();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
